axi4_ram_slave: RTL and testbench



---
 rtl/axi4_pkg.sv | 21 ++
 rtl/axi4_if.sv | 56 +++++
 rtl/axi4_burst_addr.sv | 55 +++++
 rtl/axi4_ram_slave.sv | 190 +++++++++++++++++++
 tb/tb_axi4_ram_slave.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// Shared burst/response encodings and FSM state types for the AXI4 RAM slave.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t W_IDLE = 2'd0;
    localparam wr_state_t W_DATA = 2'd1;
    localparam wr_state_t W_RESP = 2'd2;

    typedef logic [1:0] rd_state_t;
    localparam rd_state_t R_IDLE  = 2'd0;
    localparam rd_state_t R_FETCH = 2'd1;
    localparam rd_state_t R_DATA  = 2'd2;

endpackage

// File: rtl/axi4_if.sv
// AXI4 bus bundle with master and slave views; user sideband limited to B and R.
interface axi4_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic [USER_WIDTH-1:0]   buser;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic [USER_WIDTH-1:0]   ruser;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, buser, bvalid,
        output arready, rid, rdata, rresp, rlast, ruser, rvalid
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, buser, bvalid,
        input  arready, rid, rdata, rresp, rlast, ruser, rvalid
    );

endinterface

// File: rtl/axi4_burst_addr.sv
// Next-beat address and per-beat error flag for one AXI burst channel.
// WRAP address generation exists only when AXI4_RAM_SLAVE_WRAP_EN is defined.
module axi4_burst_addr
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  err
);
    localparam int OB = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH) << OB;

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic                  burst_err;
`ifdef AXI4_RAM_SLAVE_WRAP_EN
    logic [ADDR_WIDTH-1:0] wrap_mask;
`else
    logic                  unused_len;
    assign unused_len = ^len;
`endif

    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        incr_addr = addr + step;
        burst_err = (burst == 2'b11);
        next_addr = addr;
`ifdef AXI4_RAM_SLAVE_WRAP_EN
        wrap_mask = '0;
`endif
        case (burst)
            BURST_INCR: next_addr = incr_addr;
`ifdef AXI4_RAM_SLAVE_WRAP_EN
            BURST_WRAP: begin
                // region is (len+1) beats of 2^size bytes, aligned to its own size
                wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
                next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
                burst_err = !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
            end
`else
            BURST_WRAP: burst_err = 1'b1;
`endif
            default: ;
        endcase
        err = ({1'b0, addr} >= LIMIT) || (size > 3'(OB)) || burst_err;
    end

endmodule

// File: rtl/axi4_ram_slave.sv
// AXI4 slave terminating in a word-addressed on-chip RAM; independent read and write FSMs.
// Define AXI4_RAM_SLAVE_WRAP_EN to support WRAP bursts (otherwise they return SLVERR).
module axi4_ram_slave
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 1024
) (
    input logic   aclk,
    input logic   aresetn,
    axi4_if.slave s_axi
);
    localparam int OB = $clog2(DATA_WIDTH / 8);
    localparam int IW = $clog2(DEPTH);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    wr_state_t             w_state;
    logic [ADDR_WIDTH-1:0] w_addr, wa_next;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_err, wa_err, w_fire;
    logic                  awready, wready, bvalid;
    logic [1:0]            bresp;
    logic [ID_WIDTH-1:0]   bid;

    rd_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_addr, ra_next;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  ra_err;
    logic                  arready, rvalid, rlast;
    logic [1:0]            rresp;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;

    logic                  unused_wlast;
    assign unused_wlast = s_axi.wlast;

    axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_waddr (
        .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst),
        .next_addr(wa_next), .err(wa_err)
    );

    axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_raddr (
        .addr(r_addr), .len(r_len), .size(r_size), .burst(r_burst),
        .next_addr(ra_next), .err(ra_err)
    );

    assign w_fire = (w_state == W_DATA) && s_axi.wvalid && wready;

    always_ff @(posedge aclk) begin
        if (w_fire && !wa_err) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi.wstrb[b]) mem[w_addr[OB+IW-1:OB]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            bid     <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (s_axi.awvalid && awready) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        bid     <= s_axi.awid;
                        w_addr  <= s_axi.awaddr;
                        w_len   <= s_axi.awlen;
                        w_size  <= s_axi.awsize;
                        w_burst <= s_axi.awburst;
                        w_cnt   <= '0;
                        w_err   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= wa_next;
                        w_err  <= w_err | wa_err;
                        w_cnt  <= w_cnt + 8'd1;
                        // beat count, not wlast, closes the burst
                        if (w_cnt == w_len) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= (w_err | wa_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= RESP_OKAY;
            rid     <= '0;
            rdata   <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (s_axi.arvalid && arready) begin
                        arready <= 1'b0;
                        rid     <= s_axi.arid;
                        r_addr  <= s_axi.araddr;
                        r_len   <= s_axi.arlen;
                        r_size  <= s_axi.arsize;
                        r_burst <= s_axi.arburst;
                        r_cnt   <= '0;
                        r_state <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rdata   <= ra_err ? '0 : mem[r_addr[OB+IW-1:OB]];
                    rresp   <= ra_err ? RESP_SLVERR : RESP_OKAY;
                    rlast   <= (r_cnt == r_len);
                    rvalid  <= 1'b1;
                    r_state <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        rvalid <= 1'b0;
                        r_addr <= ra_next;
                        r_cnt  <= r_cnt + 8'd1;
                        if (rlast) begin
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign s_axi.awready = awready;
    assign s_axi.wready  = wready;
    assign s_axi.bvalid  = bvalid;
    assign s_axi.bresp   = bresp;
    assign s_axi.bid     = bid;
    assign s_axi.buser   = '0;
    assign s_axi.arready = arready;
    assign s_axi.rvalid  = rvalid;
    assign s_axi.rdata   = rdata;
    assign s_axi.rresp   = rresp;
    assign s_axi.rlast   = rlast;
    assign s_axi.rid     = rid;
    assign s_axi.ruser   = '0;

endmodule

// File: tb/tb_axi4_ram_slave.sv
// Randomised bench for axi4_ram_slave against a byte-array reference memory.
module tb_axi4_ram_slave;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int IDW = 4;
    localparam int DEPTH = 1024;
    localparam int MEM_BYTES = DEPTH * DW / 8;
`ifdef AXI4_RAM_SLAVE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int total = 0;
    int bad = 0;
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    axi4_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW)) bus ();

    axi4_ram_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn), .s_axi(bus)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit burst_bad(int len, int size, int burst);
        if (burst == 3 || size > 2) return 1'b1;
        if (burst == 2) return !WRAP_EN || !(len == 1 || len == 3 || len == 7 || len == 15);
        return 1'b0;
    endfunction

    function automatic int beat_addr(int start, int len, int size, int burst, int i);
        int step, region, base;
        step = 1 << size;
        if (burst == 0) return start;
        if (burst == 2) begin
            region = (len + 1) * step;
            base = start - (start % region);
            return base + ((start - base + i * step) % region);
        end
        return (start + i * step) % 65536;
    endfunction

    function automatic logic [31:0] ref_word(int a);
        int w;
        w = a - (a % 4);
        return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
    endfunction

    task automatic axi_write(input int addr, input int len, input int size, input int burst, input int id);
        int n, a;
        bit err, any_err;
        bus.awaddr = AW'(addr);
        bus.awlen = 8'(len);
        bus.awsize = 3'(size);
        bus.awburst = 2'(burst);
        bus.awid = IDW'(id);
        bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 100) begin @(negedge aclk); n++; end
        check_eq("aw_ready", bus.awready, 1);
        @(negedge aclk);
        bus.awvalid = 1'b0;
        any_err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i == 0) check_eq("w_first_ready", bus.wready, 1);
            if ($urandom_range(0, 3) == 0) @(negedge aclk);
            bus.wdata = wd[i];
            bus.wstrb = ws[i];
            bus.wlast = (i == len);
            bus.wvalid = 1'b1;
            n = 0;
            while (!bus.wready && n < 100) begin @(negedge aclk); n++; end
            check_eq("w_ready", bus.wready, 1);
            @(negedge aclk);
            bus.wvalid = 1'b0;
            a = beat_addr(addr, len, size, burst, i);
            err = burst_bad(len, size, burst) || a >= MEM_BYTES;
            any_err |= err;
            if (!err)
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) ref_mem[a - (a % 4) + b] = wd[i][8*b +: 8];
        end
        check_eq("b_valid_rise", bus.bvalid, 1);
        repeat ($urandom_range(0, 2)) @(negedge aclk);
        check_eq("b_resp", bus.bresp, any_err ? 2'b10 : 2'b00);
        check_eq("b_id", bus.bid, id);
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
        check_eq("b_valid_drop", bus.bvalid, 0);
    endtask

    task automatic axi_read(input int addr, input int len, input int size, input int burst, input int id,
                            input bit stall);
        int n, a;
        bit err;
        logic [31:0] exp;
        bus.araddr = AW'(addr);
        bus.arlen = 8'(len);
        bus.arsize = 3'(size);
        bus.arburst = 2'(burst);
        bus.arid = IDW'(id);
        bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 100) begin @(negedge aclk); n++; end
        check_eq("ar_ready", bus.arready, 1);
        @(negedge aclk);
        bus.arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            n = 0;
            while (!bus.rvalid && n < 100) begin @(negedge aclk); n++; end
            if (i == 0) check_eq("r_first_latency", n, 1);
            check_eq("r_valid", bus.rvalid, 1);
            a = beat_addr(addr, len, size, burst, i);
            err = burst_bad(len, size, burst) || a >= MEM_BYTES;
            exp = err ? 32'h0 : ref_word(a);
            check_eq("r_data", bus.rdata, exp);
            check_eq("r_resp", bus.rresp, err ? 2'b10 : 2'b00);
            check_eq("r_last", bus.rlast, i == len);
            check_eq("r_id", bus.rid, id);
            if (stall || $urandom_range(0, 2) == 0) begin
                @(negedge aclk);
                check_eq("r_hold_valid", bus.rvalid, 1);
                check_eq("r_hold_data", bus.rdata, exp);
                check_eq("r_hold_id", bus.rid, id);
            end
            bus.rready = 1'b1;
            @(negedge aclk);
            bus.rready = 1'b0;
        end
    endtask

    initial begin
        bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.rready = 1'b0;

        repeat (5) @(negedge aclk);
        check_eq("rst_awready", bus.awready, 0);
        check_eq("rst_wready", bus.wready, 0);
        check_eq("rst_bvalid", bus.bvalid, 0);
        check_eq("rst_bresp", bus.bresp, 0);
        check_eq("rst_bid", bus.bid, 0);
        check_eq("rst_arready", bus.arready, 0);
        check_eq("rst_rvalid", bus.rvalid, 0);
        check_eq("rst_rdata", bus.rdata, 0);
        check_eq("rst_rresp", bus.rresp, 0);
        check_eq("rst_rlast", bus.rlast, 0);
        check_eq("rst_rid", bus.rid, 0);
        aresetn = 1'b1;
        #1;
        check_eq("rel_awready_pre", bus.awready, 0);
        @(negedge aclk);
        check_eq("rel_awready", bus.awready, 1);
        check_eq("rel_arready", bus.arready, 1);

        // preload every word so later reads compare against known data
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            axi_write(blk * 1024, 255, 2, 1, blk);
        end

        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
        axi_write(16, 3, 2, 1, 5);
        axi_read(16, 3, 2, 1, 6, 1'b0);

        axi_read(56, 3, 2, 2, 7, 1'b0);

        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        axi_write(0, 0, 2, 1, 1);
        wd[0] = 32'h0000_5500; ws[0] = 4'h2;
        axi_write(1, 0, 0, 1, 2);
        axi_read(0, 0, 2, 1, 3, 1'b0);
        check_eq("narrow_word", bus.rdata, 32'hFFFF_55FF);

        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        axi_write(MEM_BYTES, 0, 2, 1, 4);
        axi_read(0, 0, 2, 1, 4, 1'b0);

        axi_read(64, 7, 2, 1, 9, 1'b1);

        for (int t = 0; t < 40; t++) begin
            int r, burst, size, len, addr, id;
            r = int'($urandom_range(0, 9));
            burst = (r == 0) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
            size = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            len = (burst == 2 && $urandom_range(0, 4) != 0) ? (1 << $urandom_range(1, 4)) - 1
                                                             : int'($urandom_range(0, 15));
            addr = int'($urandom_range(0, MEM_BYTES + 64));
            id = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
                axi_write(addr, len, size, burst, id);
            end else begin
                axi_read(addr, len, size, burst, id, 1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
